// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port: grants one
// writeback requester per cycle and registers a one-hot write enable plus data.
module regfile_write_arbiter #(
  parameter int NREQ       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int NREG      = 2 ** ADDR_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       hold_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic [NREG-1:0]            wr_enable_o,
  output logic [DATA_WIDTH-1:0]      wr_data_o,
  output logic [IDW-1:0]             wr_grant_id_o,
  output logic                       wr_active_o
);

  logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
  logic [DATA_WIDTH-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [NREG-1:0]       wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [IDW-1:0]        wr_id_q, wr_id_d;
  logic                  wr_act_q, wr_act_d;

  logic                  found;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW:0]          cand;

  // Scan from the pointer upward, wrapping modulo NREQ; first valid wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!hold_i && !reset_i) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
        if (!found && req_valid_i[cand[IDW-1:0]]) begin
          found   = 1'b1;
          gnt_idx = cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    ptr_d       = ptr_q;
    wr_en_d     = '0;
    wr_act_d    = 1'b0;
    wr_data_d   = wr_data_q;
    wr_id_d     = wr_id_q;
    if (found) begin
      req_ready_o = NREQ'(1) << gnt_idx;
      ptr_d       = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      wr_en_d     = NREG'(1) << addr_arr[gnt_idx];
      wr_act_d    = 1'b1;
      wr_data_d   = data_arr[gnt_idx];
      wr_id_d     = gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      wr_id_q   <= '0;
      wr_act_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_id_q   <= wr_id_d;
      wr_act_q  <= wr_act_d;
    end
  end

  assign wr_enable_o   = wr_en_q;
  assign wr_data_o     = wr_data_q;
  assign wr_grant_id_o = wr_id_q;
  assign wr_active_o   = wr_act_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based requester/pointer
// model predicts grants and registered writes; a negedge monitor checks them.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 4;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            hold_i;
  logic [NREQ-1:0] req_valid_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0] req_ready_o;
  logic [15:0]     wr_enable_o;
  logic [DW-1:0]   wr_data_o;
  logic [1:0]      wr_grant_id_o;
  logic            wr_active_o;

  regfile_write_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hold_i(hold_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .wr_enable_o(wr_enable_o), .wr_data_o(wr_data_o),
    .wr_grant_id_o(wr_grant_id_o), .wr_active_o(wr_active_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file bank fed by the arbiter's write port.
  logic [DW-1:0] rf [16];
  always @(posedge clk_i)
    for (int i = 0; i < 16; i++) if (wr_enable_o[i]) rf[i] <= wr_data_o;

  typedef struct {
    logic          active;
    logic [15:0]   en;
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic [3:0]    addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  logic pend_vld = 1'b0;

  int errors = 0;
  int checks = 0;

  logic          s_valid [NREQ];
  logic [AW-1:0] s_addr  [NREQ];
  logic [DW-1:0] s_data  [NREQ];
  int            m_ptr = 0;
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_id = '0;
  logic [DW-1:0] model_rf  [16];
  logic          model_vld [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (s_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // mode: 0 keep granted source valid, 1 retire it, 2 refill randomly
  task automatic step(input logic rst, input logic hld, input int mode);
    int g;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    @(posedge clk_i); #1;
    if (pend_vld) exp_q.push_back(pend);
    reset_i = rst;
    hold_i  = hld;
    for (int i = 0; i < NREQ; i++) begin
      req_valid_i[i] = s_valid[i];
      req_addr_i[i*AW +: AW] = s_addr[i];
      req_data_i[i*DW +: DW] = s_data[i];
    end
    #1;
    g = (rst || hld) ? -1 : model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    e.active = 1'b0; e.en = '0; e.addr = '0;
    if (rst) begin
      m_ptr = 0; m_data = '0; m_id = '0;
    end else if (g >= 0) begin
      e.active = 1'b1;
      e.en     = 16'(1) << s_addr[g];
      e.addr   = s_addr[g];
      m_data   = s_data[g];
      m_id     = 2'(g);
      m_ptr    = (g + 1) % NREQ;
      if (mode == 1) s_valid[g] = 1'b0;
      if (mode == 2) begin
        s_valid[g] = ($urandom_range(0, 3) != 0);
        s_addr[g]  = AW'($urandom);
        s_data[g]  = $urandom;
      end
    end
    e.data = m_data;
    e.id   = m_id;
    pend = e;
    pend_vld = 1'b1;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_active", 64'(wr_active_o), 64'(e.active));
      chk("wr_enable", 64'(wr_enable_o), 64'(e.en));
      chk("wr_data", 64'(wr_data_o), 64'(e.data));
      chk("wr_grant_id", 64'(wr_grant_id_o), 64'(e.id));
      if (!$onehot0(wr_enable_o)) chk("wr_enable_onehot", 64'(wr_enable_o), 64'd0);
      if (e.active) begin
        model_rf[e.addr]  = e.data;
        model_vld[e.addr] = 1'b1;
      end
    end
  end

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_valid[i] = v; s_addr[i] = a; s_data[i] = d;
  endtask

  initial begin
    reset_i = 1'b1; hold_i = 1'b0;
    req_valid_i = '1; req_addr_i = '0; req_data_i = '0;
    for (int i = 0; i < 16; i++) model_vld[i] = 1'b0;
    for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, AW'(i), DW'(i));

    // Reset with all requesters valid.
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // Single write from requester 1.
    for (int i = 0; i < NREQ; i++) s_valid[i] = 1'b0;
    set_src(1, 1'b1, 4'd5, 32'hAAAAAAAA);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);

    // Round robin, all valid, addresses 1/2/3.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, AW'(i + 1), 32'h1000_0000 + DW'(i));
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 0);

    // Pointer wrap: last grant was requester 2.
    s_valid[1] = 1'b0;
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);

    // Hold for three cycles with everything valid.
    for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, AW'(i + 7), 32'h2000_0000 + DW'(i));
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // Same-destination conflict on register 15.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < NREQ; i++) s_valid[i] = 1'b0;
    set_src(0, 1'b1, 4'd15, 32'h11111111);
    set_src(1, 1'b1, 4'd15, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    chk("rf15_conflict", 64'(rf[15]), 64'h0000_0000_FFFF_FFFF);

    // Randomized traffic with occasional hold and mid-run reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!s_valid[i] && $urandom_range(0, 2) == 0)
          set_src(i, 1'b1, AW'($urandom), $urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, 2);
    end

    for (int i = 0; i < NREQ; i++) s_valid[i] = 1'b0;
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    @(negedge clk_i); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 16; i++)
      if (model_vld[i]) chk("regfile_contents", 64'(rf[i]), 64'(model_rf[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 16-entry ARM register file between multiple writeback requesters: the ALU result path, the load-data return path and the branch-with-link path. Each cycle it picks one valid requester using round-robin priority and completes a valid/ready handshake with it. It then drives a registered one-hot write enable, plus the data, into the bank of 32-bit enable-gated registers. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 4, register index width; register file has 2**ADDR_WIDTH entries

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- hold  input  1  pipeline freeze; when 1, no grant is issued this cycle
- req_valid  input  NREQ  requester i presents a write
- req_addr  input  NREQ*ADDR_WIDTH  destination index, requester i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NREQ*DATA_WIDTH  write data, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NREQ  one-hot grant; combinational, same cycle
- wr_enable  output  2**ADDR_WIDTH  registered one-hot register write enables
- wr_data  output  DATA_WIDTH  registered write data, common to all registers
- wr_grant_id  output  clog2(NREQ)  registered index of the requester whose write is on wr_*
- wr_active  output  1  registered; 1 when wr_enable is non-zero

## Operation
- A handshake completes for requester i in a cycle when req_valid[i] && req_ready[i].
  - Requesters must hold valid, addr and data stable until the handshake completes.
- Grant rule, evaluated each cycle with hold=0 and reset=0:
  - Scan requesters starting at priority pointer p, upward modulo NREQ.
  - The first one with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - If no requester is valid, req_ready=0.
- When hold=1 or reset=1, req_ready=0 regardless of valid.
- Priority pointer p, state width clog2(NREQ):
  - On a completed handshake by requester g, p <= (g+1) mod NREQ. Wrap from NREQ-1 goes to 0.
  - With no handshake, p holds.
- Output stage, on the same edge as the handshake:
  - wr_enable <= 1 << req_addr[g]
  - wr_data <= req_data[g]
  - wr_grant_id <= g
  - wr_active <= 1
  - With no handshake: wr_enable <= 0, wr_active <= 0. wr_data and wr_grant_id hold their last values.
- At most one wr_enable bit is set in any cycle, so the port never sees a dual write.
- Two requesters targeting the same index in one cycle are serialized: the first granted writes first, the second writes in a later cycle. Last write wins in the file.
- No special treatment of index 15 (PC); it is written like any other register.

## Timing
- Reset values, after the first rising edge with reset=1:
  - p=0 (requester 0 highest priority)
  - wr_enable=0, wr_data=0, wr_grant_id=0, wr_active=0
- Reset mid-operation:
  - Any write captured on the previous edge still appears on wr_* during the cycle in which reset is asserted.
  - The reset edge clears the outputs.
  - No handshake completes in a cycle with reset=1.
- Latency:
  - Handshake in cycle N, so wr_enable is asserted during cycle N+1 for exactly one cycle.
  - The register file captures the data on the edge ending cycle N+1.
  - The new value is visible on the register output in cycle N+2.
- Throughput: one write per cycle, sustained. Back-to-back grants produce wr_enable in consecutive cycles.
- hold asserted in cycle N:
  - No grant in N, so wr_active=0 in N+1.
  - A write granted in N-1 still completes in cycle N.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.

## Test plan
- Reset: assert reset for 2 cycles with all req_valid=1 -> req_ready=0 throughout; then wr_enable=0, wr_data=0, wr_active=0, p=0.
- Single write: req_valid=3'b010, addr1=4'd5, data1=32'hAAAAAAAA in cycle N -> req_ready=3'b010 in N; wr_enable=16'h0020 and wr_data=32'hAAAAAAAA in N+1; wr_enable=0 in N+2.
- Round-robin: all three valid continuously, addrs 1/2/3 -> grant order 0,1,2,0,1,2; wr_enable sequence 16'h0002, 16'h0004, 16'h0008 repeating; never two bits set.
- Pointer wrap: after a grant to requester 2, present req_valid=3'b101 -> requester 0 granted; next cycle requester 2 granted.
- Hold: all valid; hold=1 for cycles N..N+2 -> req_ready=0 in N..N+2; wr_active=0 in N+1..N+3; p unchanged; granting resumes at the same requester in N+3.
- Same-destination conflict: requesters 0 and 1 both target 4'd15 with 32'h11111111 / 32'hFFFFFFFF -> two consecutive writes to register 15; the final file value is 32'hFFFFFFFF.
